// File: rtl/cdm_pkg.sv
// Shared definitions for the carry-disregard multiplier error monitor:
// default sizes, FSM state encoding and the saturating accumulate helper.
package cdm_pkg;

    localparam int CDM_WIDTH = 16;
    localparam int PROD_W    = 2 * CDM_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ERR  = 2'd2,
        ACC  = 2'd3
    } state_e;

    // Adds inc to acc and clamps at maxVal; operands are zero-extended to 64 bits.
    function automatic logic [63:0] satInc(input logic [63:0] acc,
                                           input logic [63:0] inc,
                                           input logic [63:0] maxVal);
        logic [64:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        if (sum > {1'b0, maxVal}) begin
            satInc = maxVal;
        end else begin
            satInc = sum[63:0];
        end
    endfunction

endpackage

// File: rtl/cdm_seq_mul.sv
// Iterative shift-add exact multiplier: one partial product per cycle,
// WIDTH cycles from start to final product.
module cdm_seq_mul
    import cdm_pkg::*;
#(
    parameter int WIDTH = CDM_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int PW = 2 * WIDTH;
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] aOp_q;
    logic [WIDTH-1:0] bOp_q;
    logic [PW-1:0]    prod_q;
    logic [KW-1:0]    bitIdx_q;
    logic             running_q;

    // High during the cycle that performs the last iteration.
    assign done_o = running_q && (bitIdx_q == KW'(WIDTH - 1));
    assign prod_o = prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aOp_q     <= '0;
            bOp_q     <= '0;
            prod_q    <= '0;
            bitIdx_q  <= '0;
            running_q <= 1'b0;
        end else if (abort_i) begin
            running_q <= 1'b0;
        end else if (start_i) begin
            aOp_q     <= a_i;
            bOp_q     <= b_i;
            prod_q    <= '0;
            bitIdx_q  <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            if (bOp_q[bitIdx_q]) begin
                prod_q <= prod_q + (PW'(aOp_q) << bitIdx_q);
            end
            bitIdx_q <= bitIdx_q + KW'(1);
            if (done_o) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cdm_err_monitor.sv
// Streaming error-statistics collector: recomputes A*B exactly, forms |A*B - R|
// and keeps saturating sample/error counts, error sum, max and last error.
module cdm_err_monitor
    import cdm_pkg::*;
#(
    parameter int WIDTH = PROD_W / 2,
    parameter int CNT_W = 32,
    parameter int SUM_W = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2*WIDTH-1:0] in_r,
    output logic               busy,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [SUM_W-1:0]   sum_ed,
    output logic [2*WIDTH-1:0] max_ed,
    output logic [2*WIDTH-1:0] last_ed
);

    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    state_e          state_q;
    logic [PW-1:0]   r_q;
    logic [PW-1:0]   lastEd_q;
    logic [PW-1:0]   maxEd_q;
    logic [CNT_W-1:0] sampleCnt_q;
    logic [CNT_W-1:0] errCnt_q;
    logic [SUM_W-1:0] sumEd_q;

    logic [CNT_W-1:0] sampleCnt_d;
    logic [CNT_W-1:0] errCnt_d;
    logic [SUM_W-1:0] sumEd_d;
    logic [PW-1:0]    maxEd_d;
    logic [PW-1:0]    ed;
    logic [PW-1:0]    prod;
    logic             mulDone;
    logic             accept;

    assign in_ready = (state_q == IDLE) && !clear;
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;

    cdm_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort_i (clear),
        .start_i (accept),
        .a_i     (in_a),
        .b_i     (in_b),
        .done_o  (mulDone),
        .prod_o  (prod)
    );

    assign ed = (prod >= r_q) ? (prod - r_q) : (r_q - prod);

    // Accumulator updates are computed from the registered last error.
    always_comb begin
        sampleCnt_d = CNT_W'(satInc(64'(sampleCnt_q), 64'd1, 64'(CNT_MAX)));
        errCnt_d    = errCnt_q;
        if (lastEd_q != '0) begin
            errCnt_d = CNT_W'(satInc(64'(errCnt_q), 64'd1, 64'(CNT_MAX)));
        end
        sumEd_d = SUM_W'(satInc(64'(sumEd_q), 64'(lastEd_q), 64'(SUM_MAX)));
        maxEd_d = (lastEd_q > maxEd_q) ? lastEd_q : maxEd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            lastEd_q    <= '0;
            maxEd_q     <= '0;
            sampleCnt_q <= '0;
            errCnt_q    <= '0;
            sumEd_q     <= '0;
        end else if (clear) begin
            state_q     <= IDLE;
            lastEd_q    <= '0;
            maxEd_q     <= '0;
            sampleCnt_q <= '0;
            errCnt_q    <= '0;
            sumEd_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        r_q     <= in_r;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    if (mulDone) begin
                        state_q <= ERR;
                    end
                end
                ERR: begin
                    lastEd_q <= ed;
                    state_q  <= ACC;
                end
                ACC: begin
                    sampleCnt_q <= sampleCnt_d;
                    errCnt_q    <= errCnt_d;
                    sumEd_q     <= sumEd_d;
                    maxEd_q     <= maxEd_d;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample_cnt = sampleCnt_q;
    assign err_cnt    = errCnt_q;
    assign sum_ed     = sumEd_q;
    assign max_ed     = maxEd_q;
    assign last_ed    = lastEd_q;

endmodule

// File: tb/tb_cdm_err_monitor.sv
// Directed bench for cdm_err_monitor; a second instance with 4-bit counters
// shares the stimulus so counter saturation can be observed.
module tb_cdm_err_monitor;
    import cdm_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic [15:0]       in_a = '0;
    logic [15:0]       in_b = '0;
    logic [PROD_W-1:0] in_r = '0;

    logic              in_ready, busy;
    logic [31:0]       sample_cnt, err_cnt;
    logic [47:0]       sum_ed;
    logic [PROD_W-1:0] max_ed, last_ed;

    logic              sat_in_ready, sat_busy;
    logic [3:0]        sat_sample_cnt, sat_err_cnt;
    logic [47:0]       sat_sum_ed;
    logic [PROD_W-1:0] sat_max_ed, sat_last_ed;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    cdm_err_monitor #(.WIDTH(16), .CNT_W(32), .SUM_W(48)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_r(in_r),
        .busy(busy), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .sum_ed(sum_ed), .max_ed(max_ed), .last_ed(last_ed)
    );

    cdm_err_monitor #(.WIDTH(16), .CNT_W(4), .SUM_W(48)) dutSat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(sat_in_ready), .in_a(in_a), .in_b(in_b), .in_r(in_r),
        .busy(sat_busy), .sample_cnt(sat_sample_cnt), .err_cnt(sat_err_cnt),
        .sum_ed(sat_sum_ed), .max_ed(sat_max_ed), .last_ed(sat_last_ed)
    );

    task automatic doClear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    // Offers one sample and returns 1 time unit after the accept edge.
    task automatic sendSample(input logic [15:0] a, input logic [15:0] b,
                              input logic [PROD_W-1:0] r);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checkCount++; failCount++;
            $display("[TB] FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        in_a = a; in_b = b; in_r = r; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDone();
        int waited = 0;
        while (busy && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (busy) begin
            checkCount++; failCount++;
            $display("[TB] FAIL done_timeout: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checkCount++;
        if (sample_cnt !== 32'd0 || err_cnt !== 32'd0 || sum_ed !== 48'd0 ||
            max_ed !== '0 || last_ed !== '0 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_stats: cnt=%0h err=%0h sum=%0h max=%0h last=%0h busy=%0b required all 0",
                     sample_cnt, err_cnt, sum_ed, max_ed, last_ed, busy);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkCount++;
        if (in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_ready: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_exact();
        sendSample(16'd3, 16'd5, 32'd15);
        repeat (17) @(posedge clk);
        #1;
        checkCount++;
        if (sample_cnt !== 32'd0 || busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL exact_latency_early: cnt=%0d busy=%0b required 0/1", sample_cnt, busy);
        end
        @(posedge clk); #1;
        checkCount++;
        if (sample_cnt !== 32'd1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL exact_latency: cnt=%0d busy=%0b ready=%0b required 1/0/1",
                     sample_cnt, busy, in_ready);
        end
        checkCount++;
        if (err_cnt !== 32'd0 || sum_ed !== 48'd0 || max_ed !== '0 || last_ed !== '0) begin
            failCount++;
            $display("[TB] FAIL exact_stats: err=%0d sum=%0h max=%0h last=%0h required 0",
                     err_cnt, sum_ed, max_ed, last_ed);
        end
    endtask

    task automatic test_underestimate();
        doClear();
        sendSample(16'hFFFF, 16'hFFFF, 32'd0);
        waitDone();
        checkCount++;
        if (last_ed !== 32'hFFFE0001 || max_ed !== 32'hFFFE0001) begin
            failCount++;
            $display("[TB] FAIL under_ed: last=%0h max=%0h required fffe0001", last_ed, max_ed);
        end
        checkCount++;
        if (sum_ed !== 48'hFFFE0001 || err_cnt !== 32'd1 || sample_cnt !== 32'd1) begin
            failCount++;
            $display("[TB] FAIL under_acc: sum=%0h err=%0d cnt=%0d required fffe0001/1/1",
                     sum_ed, err_cnt, sample_cnt);
        end
    endtask

    task automatic test_overestimate();
        doClear();
        sendSample(16'd2, 16'd2, 32'd10);
        waitDone();
        checkCount++;
        if (last_ed !== 32'd6) begin
            failCount++;
            $display("[TB] FAIL over_ed: last=%0d required 6", last_ed);
        end
        sendSample(16'd4, 16'd4, 32'd15);
        waitDone();
        checkCount++;
        if (sum_ed !== 48'd7 || max_ed !== 32'd6 || last_ed !== 32'd1) begin
            failCount++;
            $display("[TB] FAIL over_stats: sum=%0d max=%0d last=%0d required 7/6/1",
                     sum_ed, max_ed, last_ed);
        end
        checkCount++;
        if (err_cnt !== 32'd2 || sample_cnt !== 32'd2) begin
            failCount++;
            $display("[TB] FAIL over_counts: err=%0d cnt=%0d required 2/2", err_cnt, sample_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int lowCount = 0;
        doClear();
        in_a = 16'd3; in_b = 16'd7; in_r = 32'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        if (!in_ready) lowCount++;
        for (int i = 1; i < 18; i++) begin
            @(posedge clk); #1;
            if (!in_ready) lowCount++;
            if (i == 2) begin in_a = 16'd9; in_b = 16'd9; end
            if (i == 10) begin in_a = 16'd3; in_b = 16'd7; end
        end
        checkCount++;
        if (lowCount !== 18) begin
            failCount++;
            $display("[TB] FAIL b2b_ready_low: low cycles=%0d required 18", lowCount);
        end
        @(posedge clk); #1;
        checkCount++;
        if (in_ready !== 1'b1 || sample_cnt !== 32'd1 || last_ed !== 32'd21) begin
            failCount++;
            $display("[TB] FAIL b2b_first: ready=%0b cnt=%0d last=%0d required 1/1/21",
                     in_ready, sample_cnt, last_ed);
        end
        @(posedge clk); #1;
        checkCount++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL b2b_second_accept: ready=%0b busy=%0b required 0/1", in_ready, busy);
        end
        in_valid = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        checkCount++;
        if (sample_cnt !== 32'd2 || sum_ed !== 48'd42 || max_ed !== 32'd21) begin
            failCount++;
            $display("[TB] FAIL b2b_stats: cnt=%0d sum=%0d max=%0d required 2/42/21",
                     sample_cnt, sum_ed, max_ed);
        end
    endtask

    task automatic test_saturation();
        doClear();
        for (int i = 0; i < 20; i++) begin
            sendSample(16'd1, 16'd1, 32'd0);
            waitDone();
        end
        checkCount++;
        if (sat_sample_cnt !== 4'd15 || sat_err_cnt !== 4'd15) begin
            failCount++;
            $display("[TB] FAIL sat_counts: cnt=%0d err=%0d required 15/15", sat_sample_cnt, sat_err_cnt);
        end
        checkCount++;
        if (sat_sum_ed !== 48'd20 || sat_max_ed !== 32'd1 || sat_last_ed !== 32'd1 || sat_busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sat_stats: sum=%0d max=%0d last=%0d busy=%0b required 20/1/1/0",
                     sat_sum_ed, sat_max_ed, sat_last_ed, sat_busy);
        end
        checkCount++;
        if (sample_cnt !== 32'd20 || err_cnt !== 32'd20 || sum_ed !== 48'd20) begin
            failCount++;
            $display("[TB] FAIL wide_counts: cnt=%0d err=%0d sum=%0d required 20/20/20",
                     sample_cnt, err_cnt, sum_ed);
        end
    endtask

    task automatic test_clear_abort();
        doClear();
        sendSample(16'd3, 16'd5, 32'd0);
        waitDone();
        sendSample(16'h1234, 16'h5678, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        clear = 1'b1;
        in_valid = 1'b1;
        #1;
        checkCount++;
        if (in_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL clear_ready_gate: in_ready=%0b required 0", in_ready);
        end
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        #1;
        checkCount++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL clear_idle: ready=%0b busy=%0b required 1/0", in_ready, busy);
        end
        repeat (20) @(posedge clk);
        #1;
        checkCount++;
        if (sample_cnt !== 32'd0 || err_cnt !== 32'd0 || sum_ed !== 48'd0 ||
            max_ed !== '0 || last_ed !== '0) begin
            failCount++;
            $display("[TB] FAIL clear_stats: cnt=%0d err=%0d sum=%0h max=%0h last=%0h required 0",
                     sample_cnt, err_cnt, sum_ed, max_ed, last_ed);
        end
    endtask

    task automatic test_reset_abort();
        sendSample(16'd3, 16'd5, 32'd0);
        waitDone();
        sendSample(16'h1234, 16'h5678, 32'd0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if (sample_cnt !== 32'd0 || sum_ed !== 48'd0 || max_ed !== '0 ||
            last_ed !== '0 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset: cnt=%0d sum=%0h max=%0h last=%0h busy=%0b required 0",
                     sample_cnt, sum_ed, max_ed, last_ed, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkCount++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_release: ready=%0b busy=%0b required 1/0", in_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_underestimate();
        test_overestimate();
        test_back_to_back();
        test_saturation();
        test_clear_abort();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/cdm_err_monitor.md
Name: cdm_err_monitor

Overview:
- Streaming error-statistics collector for the carry-disregard approximate multipliers. It consumes what the multiplier bench produces, as operand pairs A, B plus the approximate product R.
- For each sample it recomputes the exact product with an iterative shift-add datapath, forms the error distance |A*B − R|, and accumulates running statistics.
- Sits beside any cdm multiplier instance as an on-chip reader/scorer, replacing offline post-processing of result files.

Parameters:
- WIDTH, 16, operand width; product width is 2*WIDTH.
- CNT_W, 32, width of the sample counter and the error counter.
- SUM_W, 48, width of the error-distance accumulator.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all statistics; aborts any in-flight sample.
- in_valid  in  1  sample offered.
- in_ready  out  1  monitor can accept a sample.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_r  in  2*WIDTH  approximate product under test.
- busy  out  1  a sample is being processed.
- sample_cnt  out  CNT_W  samples fully accumulated.
- err_cnt  out  CNT_W  samples with nonzero error distance.
- sum_ed  out  SUM_W  sum of error distances.
- max_ed  out  2*WIDTH  largest error distance seen.
- last_ed  out  2*WIDTH  error distance of the most recent sample.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters and all stat outputs are 0; busy=0; in_ready=1 once rst_n deasserts.
- FSM states:
  - IDLE: in_ready=1, busy=0. On in_valid&in_ready, latch in_a, in_b and in_r, clear the product register, set bit index k=0, go to MUL.
  - MUL: in_ready=0, busy=1. One iteration per cycle: if b[k]=1, prod += a<<k; k++. After iteration k=WIDTH−1, go to ERR. Exactly WIDTH cycles are spent in MUL.
  - ERR: busy=1. ed = (prod>=r) ? prod−r : r−prod, unsigned, 2*WIDTH bits. Register last_ed=ed. Go to ACC.
  - ACC: busy=1. Updates:
    - sample_cnt += 1.
    - err_cnt += 1 if ed != 0.
    - sum_ed += ed (ed zero-extended to SUM_W).
    - max_ed = max(max_ed, ed).
    - Go to IDLE.
- Timing:
  - Latency from the accept edge to updated stats is WIDTH+2 cycles (18 for WIDTH=16).
  - Throughput is 1 sample per WIDTH+3 cycles.
  - in_ready is high only in IDLE.
- Saturation: sample_cnt, err_cnt and sum_ed saturate at all-ones and never wrap. Once sample_cnt saturates, the other stats still update.
- clear=1 (any state):
  - Next edge zeroes every stat output and returns to IDLE.
  - A sample offered in the same cycle is not accepted: in_ready is forced to 0 while clear=1.
  - An in-flight sample is discarded with no partial update.
- rst_n asserted mid-MUL: immediate return to reset values; the sample is lost.
- Inputs in_a, in_b and in_r are only sampled at accept. Changes afterwards have no effect.
- Stats are stable registers, readable in any state.

Decomposition:
- Shared package cdm_pkg holds:
  - localparam PROD_W = 2*WIDTH;
  - the FSM state enum (IDLE, MUL, ERR, ACC) as 2-bit encoded constants;
  - the saturating-increment helper function.
- One natural sub-module: cdm_seq_mul, the WIDTH-cycle shift-add exact multiplier. It has start/done and holds the product register and bit counter.
- The monitor keeps the FSM, the error-distance logic and the accumulators.

Test Plan:
- Exact sample: A=3, B=5, R=15 → after 18 cycles sample_cnt=1, err_cnt=0, sum_ed=0, max_ed=0, last_ed=0.
- Underestimate: A=0xFFFF, B=0xFFFF, R=0 → last_ed=max_ed=0xFFFE0001, err_cnt=1, sum_ed=0xFFFE0001.
- Overestimate then smaller error: A=2, B=2, R=10 (ed=6), then A=4, B=4, R=15 (ed=1) → sum_ed=7, max_ed=6, last_ed=1, err_cnt=2, sample_cnt=2.
- Handshake/latency: hold in_valid=1 continuously → in_ready falls the cycle after accept and stays low 18 cycles, so exactly one accept per 19 cycles. in_a/in_b changes during MUL do not alter the result.
- Saturation with CNT_W=4: 20 samples with R=0, A=B=1 → sample_cnt=err_cnt=15 (held), sum_ed=20.
- Abort: accept A=0x1234, B=0x5678; assert clear at MUL cycle 5 → all stats 0, in_ready=1 the cycle after clear drops. Repeat with rst_n=0 mid-MUL → async return to reset values with no clock edge needed.
